rule_writer: RTL
================

RULE_WRITER -- requirements
Module: rule_writer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI write address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI write data width (only 32 supported).
REQ-003 SHALL have parameter RULE_FIFO_DEPTH, default 16, rule buffer entries (power of two).
REQ-004 SHALL have ports as follows; one clock, reset asynchronous active-low:
- ACLK  in  1  sole clock, rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- START  in  1  pulse; latch BASE_ADDR, clear O_COUNT/O_ERR.
- BASE_ADDR  in  32  first write address, word aligned.
- FLUSH  in  1  pulse; emit pending half-word once the buffer drains.
- I_VALID  in  1  parser rule valid.
- I_RULE  in  16  parser rule.
- I_READY  out  1  rule accepted when I_VALID && I_READY.
- O_IDLE  out  1  FSM idle, buffer empty, no half pending.
- O_COUNT  out  32  words completed (B received).
- O_ERR  out  1  sticky write error.
- M_AXI_AWADDR  out  32; M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  32; M_AXI_WSTRB  out  4; M_AXI_WLAST  out  1; M_AXI_WVALID  out  1; M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1.

Function
REQ-005 SHALL buffer accepted rules in FIFO; I_READY = !fifo_full; accepted rule visible to packer next cycle.
REQ-006 SHALL pack rules little-endian: first rule WDATA[15:0], second WDATA[31:16], WSTRB=4'b1111.
REQ-007 SHALL, on flush request with one half pending and FIFO empty, issue WDATA={16'h0,rule}, WSTRB=4'b0011.
REQ-008 SHALL latch FLUSH into flush_req; cleared when partial word issued or when no half pending and FIFO empty; FLUSH with nothing pending is a no-op.
REQ-009 SHALL use FSM S_IDLE -> S_WRITE (word ready) -> S_RESP (AW and W both accepted) -> S_IDLE (BVALID seen).
REQ-010 SHALL in S_WRITE assert AWVALID and WVALID together, drop each independently on its handshake, never re-assert either for the same word.
REQ-011 SHALL keep AWADDR/WDATA/WSTRB stable while respective VALID high; WLAST=1 whenever WVALID=1 (single beat).
REQ-012 SHALL assert BREADY only in S_RESP; on BVALID increment O_COUNT and address by 4 (32-bit wrap, no saturation).
REQ-013 SHALL keep at most one write outstanding; new word formed only in S_IDLE.
REQ-014 SHALL ignore START unless O_IDLE=1; START and I_VALID same cycle: rule accepted, belongs to new run.
REQ-015 SHALL hold O_IDLE low from first accepted rule until last word's B response.

Reset
REQ-016 SHALL, on ARESETN low, asynchronously clear FSM to S_IDLE, FIFO, half register, flush_req, address, O_COUNT, O_ERR, all VALID/READY outputs; I_READY low during reset, high first cycle after.
REQ-017 SHALL abandon an in-flight write on reset; no completion counted.

Configuration
REQ-018 With RULE_WRITER_ERRCHK_EN defined: BRESP!=2'b00 sets O_ERR, FSM parks in S_ERR (I_READY low, no writes, O_COUNT unchanged) until START.
REQ-019 Without RULE_WRITER_ERRCHK_EN: BRESP ignored, O_ERR tied 0, S_ERR absent, erroneous words counted.

Structure
REQ-020 SHALL place FSM state encodings, WSTRB_FULL/WSTRB_HALF, BRESP_OKAY in shared package rule_writer_pkg.
REQ-021 SHALL implement buffer as sub-module rule_fifo (sync, 16-bit, full/empty, first-word-fall-through).

Verification
REQ-022 START base 0x1000, rules 0x0001..0x0004, ready slave -> writes 0x00020001@0x1000, 0x00040003@0x1004; O_COUNT=2; O_IDLE=1.
REQ-023 Rule 0x0005 then FLUSH -> one write 0x00000005, WSTRB=0011 @ base; repeat FLUSH -> no write.
REQ-024 WREADY immediate, AWREADY delayed 3 cycles -> exactly one W beat, one AW, BREADY only after both.
REQ-025 AWREADY held low, push 40 rules -> I_READY falls after FIFO (16) + pack half filled; no rule lost once released.
REQ-026 ERRCHK on, BRESP=2'b10 on word 1 -> O_ERR=1, O_COUNT=0, no further AWVALID until START.
REQ-027 ARESETN low during S_RESP -> all outputs 0 asynchronously; after release, new START at 0x2000 writes correctly.

Source files
------------

// File: rtl/rule_writer_pkg.sv
// Shared types and constants for the rule writer: FSM encodings,
// write-strobe patterns and the AXI OKAY response code.
package rule_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
`ifdef RULE_WRITER_ERRCHK_EN
        ,
        S_ERR   = 2'd3
`endif
    } state_t;

    localparam logic [3:0] WSTRB_FULL = 4'b1111;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [1:0] BRESP_OKAY = 2'b00;
    localparam int         RULE_W     = 16;

endpackage

// File: rtl/rule_writer_fifo.sv
// rule_fifo: synchronous first-word-fall-through rule buffer.
// Ports: ACLK/ARESETN, clr (drop contents), wr_en/wr_data, rd_en/rd_data, full, empty.
module rule_fifo
    import rule_writer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [RULE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [RULE_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [RULE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_wr && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/rule_writer.sv
// rule_writer: packs 16-bit parser rules into 32-bit single-beat AXI writes.
// Ports: ACLK/ARESETN, START/BASE_ADDR/FLUSH control, I_VALID/I_RULE/I_READY
// rule input, O_IDLE/O_COUNT/O_ERR status, AXI AW/W/B master channels.
// Option: RULE_WRITER_ERRCHK_EN traps on non-OKAY BRESP (S_ERR until START).
module rule_writer
    import rule_writer_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int RULE_FIFO_DEPTH    = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            START,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR,
    input  logic                            FLUSH,
    input  logic                            I_VALID,
    input  logic [RULE_W-1:0]               I_RULE,
    output logic                            I_READY,
    output logic                            O_IDLE,
    output logic [31:0]                     O_COUNT,
    output logic                            O_ERR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    state_t state, state_nxt;

    logic [RULE_W-1:0]               fifo_q;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            fifo_rd;
    logic                            fifo_clr;
    logic                            push;

    logic                            half_vld;
    logic [RULE_W-1:0]               half_q;
    logic                            flush_req;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]                     cnt_q;
    logic                            aw_pend;
    logic                            w_pend;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;

    logic err_st;
    logic idle_int;
    logic acc_en;
    logic start_ok;
    logic pop_half;
    logic form_full;
    logic form_part;
    logic form;
    logic aw_ok;
    logic w_ok;
    logic b_hs;
    logic b_ok;

`ifdef RULE_WRITER_ERRCHK_EN
    logic b_bad;
    logic err_q;
    assign err_st = (state == S_ERR);
    assign b_bad  = (M_AXI_BRESP != BRESP_OKAY);
    assign b_ok   = b_hs && !b_bad;
    assign O_ERR  = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^M_AXI_BRESP;
    assign err_st = 1'b0;
    assign b_ok   = b_hs;
    assign O_ERR  = 1'b0;
`endif

    assign idle_int = (state == S_IDLE) && fifo_empty && !half_vld;
    assign acc_en   = !fifo_full && !err_st;
    assign push     = I_VALID && acc_en;
    // Reset gating keeps both status outputs low while ARESETN is held.
    assign I_READY  = ARESETN && acc_en;
    assign O_IDLE   = ARESETN && idle_int;
    assign start_ok = START && (idle_int || err_st);
    assign fifo_clr = START && err_st;

    // The half register refills whenever empty; a word is only built in S_IDLE.
    assign pop_half  = !half_vld && !fifo_empty && !err_st;
    assign form_full = (state == S_IDLE) && half_vld && !fifo_empty;
    assign form_part = (state == S_IDLE) && half_vld && fifo_empty && flush_req;
    assign form      = form_full || form_part;
    assign fifo_rd   = pop_half || form_full;

    assign aw_ok = !aw_pend || M_AXI_AWREADY;
    assign w_ok  = !w_pend || M_AXI_WREADY;
    assign b_hs  = (state == S_RESP) && M_AXI_BVALID;

    rule_fifo #(
        .DEPTH   (RULE_FIFO_DEPTH)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr     (fifo_clr),
        .wr_en   (push),
        .wr_data (I_RULE),
        .rd_en   (fifo_rd),
        .rd_data (fifo_q),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (form) state_nxt = S_WRITE;
            S_WRITE: if (aw_ok && w_ok) state_nxt = S_RESP;
`ifdef RULE_WRITER_ERRCHK_EN
            S_RESP:  if (M_AXI_BVALID) state_nxt = b_bad ? S_ERR : S_IDLE;
            S_ERR:   if (START) state_nxt = S_IDLE;
`else
            S_RESP:  if (M_AXI_BVALID) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        M_AXI_BREADY  = 1'b0;
        M_AXI_AWVALID = aw_pend;
        M_AXI_WVALID  = w_pend;
        M_AXI_WLAST   = w_pend;
        if (state == S_RESP) M_AXI_BREADY = 1'b1;
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign O_COUNT      = cnt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            half_vld  <= 1'b0;
            half_q    <= '0;
            flush_req <= 1'b0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            if (fifo_clr) begin
                half_vld  <= 1'b0;
                flush_req <= 1'b0;
            end else begin
                if (pop_half) begin
                    half_vld <= 1'b1;
                    half_q   <= fifo_q;
                end else if (form) begin
                    half_vld <= 1'b0;
                end
                // Nothing left to pad means a flush has nothing to do.
                if (form_part || (!half_vld && fifo_empty))
                    flush_req <= 1'b0;
                else if (FLUSH)
                    flush_req <= 1'b1;
            end

            if (form) begin
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
                wdata_q <= form_full ? {fifo_q, half_q} : {16'h0, half_q};
                wstrb_q <= form_full ? WSTRB_FULL : WSTRB_HALF;
            end else begin
                if (aw_pend && M_AXI_AWREADY) aw_pend <= 1'b0;
                if (w_pend && M_AXI_WREADY)   w_pend  <= 1'b0;
            end

            if (start_ok) begin
                addr_q <= BASE_ADDR;
                cnt_q  <= '0;
            end else if (b_ok) begin
                addr_q <= addr_q + C_M_AXI_ADDR_WIDTH'(4);
                cnt_q  <= cnt_q + 32'd1;
            end
        end
    end

`ifdef RULE_WRITER_ERRCHK_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)             err_q <= 1'b0;
        else if (start_ok)        err_q <= 1'b0;
        else if (b_hs && b_bad)   err_q <= 1'b1;
    end
`endif

endmodule
